// File: rtl/ibex_bloom_unit_pkg.sv
// Shared types and constants for the Bloom-filter coprocessor.
// No logic of its own; consumed by ibex_bloom_hash and ibex_bloom_unit.
package ibex_bloom_unit_pkg;

    typedef enum logic [1:0] {
        BLOOM_INSERT = 2'd0,
        BLOOM_CHECK  = 2'd1,
        BLOOM_CLEAR  = 2'd2,
        BLOOM_FILL   = 2'd3
    } bloom_op_e;

    typedef enum logic [2:0] {
        BS_IDLE   = 3'd0,
        BS_INSERT = 3'd1,
        BS_CHECK  = 3'd2,
        BS_CLEAR  = 3'd3,
        BS_RESP   = 3'd4
    } bloom_state_e;

    // Element [k] is the salt of hash k.
    localparam logic [3:0][31:0] BLOOM_SALT = {
        32'h27D4EB2F, 32'hC2B2AE35, 32'h85EBCA6B, 32'h9E3779B9
    };

    localparam int BLOOM_ROT_BASE = 5;
    localparam int BLOOM_ROT_STEP = 8;

    function automatic logic [31:0] bloom_rotl(input logic [31:0] x, input logic [4:0] r);
        return (x << r) | (x >> (6'd32 - {1'b0, r}));
    endfunction

endpackage

// File: rtl/ibex_bloom_hash.sv
// Bloom index hash k of a 32-bit key: salted rotate-xor, then xor-folded to log2(NumBits) bits.
// Purely combinational, zero latency, no flow control.
module ibex_bloom_hash
    import ibex_bloom_unit_pkg::*;
#(
    parameter int NumBits = 1024
) (
    input  logic [31:0]                key,
    input  logic [1:0]                 k,
    output logic [$clog2(NumBits)-1:0] idx
);

    localparam int IdxW      = $clog2(NumBits);
    localparam int NumChunks = (32 + IdxW - 1) / IdxW;

    logic [4:0]  rot;
    logic [31:0] mix;

    assign rot = 5'(BLOOM_ROT_BASE) + 5'(BLOOM_ROT_STEP) * {3'b000, k};
    assign mix = key ^ bloom_rotl(key, rot) ^ BLOOM_SALT[k];

    // The top chunk is shorter than IdxW when IdxW does not divide 32; the shift zero-pads it.
    always_comb begin
        idx = '0;
        for (int c = 0; c < NumChunks; c++) begin
            idx = idx ^ IdxW'(mix >> (c * IdxW));
        end
    end

endmodule

// File: rtl/ibex_bloom_unit.sv
// Bloom-filter EX-stage unit: INSERT/CHECK walk one hash per cycle, CLEAR one word per cycle, FILL 1 cycle.
// Accepts only in IDLE (req_ready_o); response is a one-cycle strobe with no backpressure; kill_i aborts INSERT/CHECK.
module ibex_bloom_unit
    import ibex_bloom_unit_pkg::*;
#(
    parameter int NumBits    = 1024,
    parameter int NumHashes  = 3,
    parameter int ClearWidth = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_key_i,
    input  logic        kill_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_result_o,
    output logic        busy_o
);

    localparam int IdxW     = $clog2(NumBits);
    localparam int FillW    = IdxW + 1;
    localparam int NumWords = NumBits / ClearWidth;
    localparam int WordW    = (NumWords > 1) ? $clog2(NumWords) : 1;

    localparam logic [1:0]       LastK    = 2'(NumHashes - 1);
    localparam logic [WordW-1:0] LastWord = WordW'(NumWords - 1);
    localparam logic [FillW-1:0] FillMax  = FillW'(NumBits);

    bloom_state_e     state, next_state;
    bloom_op_e        op;
    logic [31:0]      key;
    logic [1:0]       k_idx;
    logic [WordW-1:0] word_idx;
    logic             all_set;
    logic [FillW-1:0] fill_cnt;
    logic [31:0]      result;
    logic [NumBits-1:0] bits;

    logic [IdxW-1:0]  idx;
    logic             cur_bit;
    logic             accept;
    logic             last_k;
    logic             last_word;

    assign op        = bloom_op_e'(req_op_i);
    assign accept    = req_valid_i & (state == BS_IDLE) & ~kill_i;
    assign cur_bit   = bits[idx];
    assign last_k    = (k_idx == LastK);
    assign last_word = (word_idx == LastWord);

    ibex_bloom_hash #(
        .NumBits (NumBits)
    ) u_hash (
        .key (key),
        .k   (k_idx),
        .idx (idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= BS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        req_ready_o  = 1'b0;
        busy_o       = 1'b1;
        resp_valid_o = 1'b0;
        unique case (state)
            BS_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (accept) begin
                    unique case (op)
                        BLOOM_INSERT: next_state = BS_INSERT;
                        BLOOM_CHECK:  next_state = BS_CHECK;
                        BLOOM_CLEAR:  next_state = BS_CLEAR;
                        BLOOM_FILL:   next_state = BS_RESP;
                        default:      next_state = BS_IDLE;
                    endcase
                end
            end
            BS_INSERT: begin
                if (kill_i) begin
                    next_state = BS_IDLE;
                end else if (last_k) begin
                    next_state = BS_RESP;
                end
            end
            BS_CHECK: begin
                if (kill_i) begin
                    next_state = BS_IDLE;
                end else if (!cur_bit || last_k) begin
                    next_state = BS_RESP;
                end
            end
            BS_CLEAR: begin
                if (last_word) begin
                    next_state = BS_RESP;
                end
            end
            BS_RESP: begin
                resp_valid_o = 1'b1;
                next_state   = BS_IDLE;
            end
            default: next_state = BS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bits     <= '0;
            fill_cnt <= '0;
            key      <= '0;
            k_idx    <= '0;
            word_idx <= '0;
            all_set  <= 1'b0;
            result   <= '0;
        end else begin
            unique case (state)
                BS_IDLE: begin
                    if (accept) begin
                        key      <= req_key_i;
                        k_idx    <= '0;
                        word_idx <= '0;
                        all_set  <= 1'b1;
                        if (op == BLOOM_FILL) begin
                            result <= 32'(fill_cnt);
                        end
                    end
                end
                BS_INSERT: begin
                    // A killed cycle writes nothing, so fill_cnt stays equal to the popcount.
                    if (!kill_i) begin
                        bits[idx] <= 1'b1;
                        if (!cur_bit && fill_cnt != FillMax) begin
                            fill_cnt <= fill_cnt + FillW'(1);
                        end
                        all_set <= all_set & cur_bit;
                        if (last_k) begin
                            result <= {31'b0, all_set & cur_bit};
                        end else begin
                            k_idx <= k_idx + 2'd1;
                        end
                    end
                end
                BS_CHECK: begin
                    if (!kill_i) begin
                        if (!cur_bit) begin
                            result <= 32'd0;
                        end else if (last_k) begin
                            result <= 32'd1;
                        end else begin
                            k_idx <= k_idx + 2'd1;
                        end
                    end
                end
                BS_CLEAR: begin
                    for (int w = 0; w < NumWords; w++) begin
                        if (word_idx == WordW'(w)) begin
                            bits[w*ClearWidth +: ClearWidth] <= '0;
                        end
                    end
                    if (last_word) begin
                        fill_cnt <= '0;
                        result   <= 32'd0;
                    end else begin
                        word_idx <= word_idx + WordW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_result_o = result;

endmodule

// File: tb/tb_ibex_bloom_unit.sv
// Bench for ibex_bloom_unit: four parameter sets run side by side, each against its own array model.
module tb_ibex_bloom_unit;

    localparam logic [1:0] OP_INS = 2'd0;
    localparam logic [1:0] OP_CHK = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;
    localparam logic [1:0] OP_FIL = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input int cfg, input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL c%0d.%s: got %0h expected %0h at %0t", cfg, tag, got, exp, $time);
        end
    endtask

    // Hash k of key: rotate via a doubled key, then fold each mix bit onto bit (b mod iw).
    function automatic int ref_idx(input logic [31:0] key, input int k, input int iw);
        logic [31:0] salt;
        logic [63:0] dbl;
        logic [31:0] mix;
        int r;
        int idx;
        case (k)
            0:       salt = 32'h9E3779B9;
            1:       salt = 32'h85EBCA6B;
            2:       salt = 32'hC2B2AE35;
            default: salt = 32'h27D4EB2F;
        endcase
        r   = 5 + 8 * k;
        dbl = {key, key};
        mix = key ^ 32'(dbl >> (32 - r)) ^ salt;
        idx = 0;
        for (int b = 0; b < 32; b++) begin
            if (mix[b]) idx = idx ^ (1 << (b % iw));
        end
        return idx;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int NB = (g == 0) ? 1024 : (g == 2) ? 4096 : 64;
        localparam int NH = (g == 0) ? 3 : (g == 1) ? 1 : 4;
        localparam int CW = (g == 3) ? 8 : 32;
        localparam int NW = NB / CW;
        localparam int IW = $clog2(NB);

        logic        rst, req_valid, req_ready, kill, resp_valid, busy;
        logic [1:0]  req_op;
        logic [31:0] req_key, resp_result;
        bit          mb [NB];
        bit          done = 1'b0;
        logic [31:0] pool [8];

        ibex_bloom_unit #(
            .NumBits    (NB),
            .NumHashes  (NH),
            .ClearWidth (CW)
        ) dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .req_valid_i   (req_valid),
            .req_ready_o   (req_ready),
            .req_op_i      (req_op),
            .req_key_i     (req_key),
            .kill_i        (kill),
            .resp_valid_o  (resp_valid),
            .resp_result_o (resp_result),
            .busy_o        (busy)
        );

        function automatic int pop();
            int c = 0;
            foreach (mb[i]) c += int'(mb[i]);
            return c;
        endfunction

        task automatic model(input logic [1:0] op, input logic [31:0] key,
                             output logic [31:0] res, output int lat);
            int i;
            bit all;
            res = 0;
            lat = 1;
            case (op)
                OP_INS: begin
                    all = 1'b1;
                    for (int k = 0; k < NH; k++) begin
                        i = ref_idx(key, k, IW);
                        all = all & mb[i];
                        mb[i] = 1'b1;
                    end
                    res = {31'b0, all};
                    lat = NH + 1;
                end
                OP_CHK: begin
                    res = 1;
                    lat = NH + 1;
                    for (int k = 0; k < NH; k++) begin
                        i = ref_idx(key, k, IW);
                        if (res == 1 && !mb[i]) begin
                            res = 0;
                            lat = k + 2;
                        end
                    end
                end
                OP_CLR: begin
                    foreach (mb[j]) mb[j] = 1'b0;
                    lat = NW + 1;
                end
                default: res = 32'(pop());
            endcase
        endtask

        // Issue one request, wait (bounded) for the strobe while throwing ignored requests at the unit.
        task automatic do_op(input logic [1:0] op, input logic [31:0] key, input int kill_at,
                             output logic [31:0] res, output int lat);
            bit got = 1'b0;
            res = 0;
            lat = -1;
            check(g, "ready_idle", req_ready, 1);
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = op;
            req_key   = key;
            @(posedge clk); #1;
            for (int n = 1; n <= NW + NH + 8 && !got; n++) begin
                kill = (n == kill_at);
                if (resp_valid) begin
                    got = 1'b1;
                    lat = n;
                    res = resp_result;
                end else begin
                    check(g, "busy_wait", busy, 1);
                    check(g, "ready_wait", req_ready, 0);
                end
                req_valid = 1'($urandom_range(0, 1));
                req_op    = 2'($urandom);
                req_key   = $urandom;
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            kill      = 1'b0;
            if (got) begin
                check(g, "strobe_once", resp_valid, 0);
                check(g, "result_hold", resp_result, res);
            end else begin
                check(g, "resp_timeout", 0, 1);
            end
        endtask

        task automatic run(input logic [1:0] op, input logic [31:0] key, input int kill_at);
            logic [31:0] eres, res;
            int elat, lat;
            model(op, key, eres, elat);
            do_op(op, key, kill_at, res, lat);
            check(g, $sformatf("lat_op%0d", op), lat, elat);
            check(g, $sformatf("res_op%0d", op), res, eres);
        endtask

        // Kill asserted in cycle c after accept; only hashes 0..c-2 have been applied.
        task automatic kill_op(input logic [1:0] op, input logic [31:0] key, input int c);
            if (op == OP_INS) begin
                for (int k = 0; k < c - 1; k++) mb[ref_idx(key, k, IW)] = 1'b1;
            end
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = op;
            req_key   = key;
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int n = 1; n < c; n++) begin
                check(g, "kill_no_resp", resp_valid, 0);
                @(posedge clk); #1;
            end
            kill = 1'b1;
            @(posedge clk); #1;
            kill = 1'b0;
            check(g, "kill_busy", busy, 0);
            check(g, "kill_resp", resp_valid, 0);
            check(g, "kill_ready", req_ready, 1);
        endtask

        task automatic reset_mid(input logic [1:0] op, input int c);
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = op;
            req_key   = $urandom;
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int n = 1; n < c; n++) begin
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            foreach (mb[j]) mb[j] = 1'b0;
            check(g, "rst_ready", req_ready, 1);
            check(g, "rst_busy", busy, 0);
            check(g, "rst_resp", resp_valid, 0);
            check(g, "rst_result", resp_result, 0);
        endtask

        initial begin
            int r;
            logic [31:0] k;
            rst = 1'b1; req_valid = 1'b0; kill = 1'b0; req_op = '0; req_key = '0;
            foreach (pool[i]) pool[i] = $urandom;
            repeat (2) @(posedge clk);
            #1;
            check(g, "reset_ready", req_ready, 1);
            check(g, "reset_resp", resp_valid, 0);
            check(g, "reset_result", resp_result, 0);
            check(g, "reset_busy", busy, 0);
            rst = 1'b0;

            run(OP_CHK, 32'h00000000, 0);
            run(OP_FIL, 32'h0, 0);
            run(OP_INS, 32'h12345678, 0);
            run(OP_FIL, 32'h0, 0);
            run(OP_CHK, 32'h12345678, 0);
            run(OP_INS, 32'h12345678, 0);
            run(OP_FIL, 32'h0, 0);
            run(OP_INS, 32'hDEADBEEF, 0);
            run(OP_FIL, 32'h0, 0);
            run(OP_CLR, 32'h0, NW / 2 + 1);
            run(OP_FIL, 32'h0, 0);
            run(OP_CHK, 32'h12345678, 0);
            run(OP_INS, 32'h12345678, NH + 1);
            kill_op(OP_INS, 32'hCAFEF00D, (NH >= 2) ? 2 : 1);
            run(OP_FIL, 32'h0, 0);
            run(OP_CHK, 32'hCAFEF00D, 0);
            kill_op(OP_CHK, 32'h12345678, 1);

            @(negedge clk);
            req_valid = 1'b1; req_op = OP_INS; req_key = 32'h0BADCAFE; kill = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0; kill = 1'b0;
            check(g, "kill_accept_busy", busy, 0);
            @(posedge clk); #1;
            check(g, "kill_accept_resp", resp_valid, 0);
            run(OP_FIL, 32'h0, 0);

            reset_mid(OP_INS, (NH >= 2) ? 2 : 1);
            run(OP_FIL, 32'h0, 0);
            run(OP_INS, 32'hDEADBEEF, 0);
            reset_mid(OP_CLR, 2);
            run(OP_FIL, 32'h0, 0);

            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 99);
                k = pool[$urandom_range(0, 7)];
                if (r % 10 == 3) kill_op(OP_INS, k, $urandom_range(1, NH));
                else if (r < 40) run(OP_INS, k, 0);
                else if (r < 80) run(OP_CHK, k, 0);
                else if (r < 96) run(OP_FIL, 32'h0, 0);
                else run(OP_CLR, 32'h0, 0);
            end
            run(OP_FIL, 32'h0, 0);
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000; i++) begin
            if (cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) break;
            @(posedge clk);
        end
        if (!(cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done)) begin
            check(-1, "global_timeout", 0, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
